// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Holds the decoded instruction for the EX stage and the forwarding unit.
// On a load-use hazard it stalls PC and IF/ID and inserts a bubble.
// On a branch flush it squashes the ID instruction.
// It keeps saturating counts of inserted stall bubbles and flushes.
module id_ex_stage #(
    parameter int DATA_W = 8,
    parameter int RA_W   = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic [RA_W-1:0]   id_rd,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_alu_src,
    input  logic              id_branch,
    input  logic [2:0]        id_alu_op,
    input  logic              flush,
    input  logic              hold,
    output logic              ex_valid,
    output logic [RA_W-1:0]   ex_rs,
    output logic [RA_W-1:0]   ex_rt,
    output logic [RA_W-1:0]   ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic              ex_branch,
    output logic [2:0]        ex_alu_op,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Increment that sticks at the maximum value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    logic              ex_valid_r;
    logic [RA_W-1:0]   ex_rs_r;
    logic [RA_W-1:0]   ex_rt_r;
    logic [RA_W-1:0]   ex_rd_r;
    logic [DATA_W-1:0] ex_rs_data_r;
    logic [DATA_W-1:0] ex_rt_data_r;
    logic [DATA_W-1:0] ex_imm_r;
    logic              ex_reg_write_r;
    logic              ex_mem_read_r;
    logic              ex_mem_write_r;
    logic              ex_mem_to_reg_r;
    logic              ex_alu_src_r;
    logic              ex_branch_r;
    logic [2:0]        ex_alu_op_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    logic              lu_s;
    logic              rs_hit_s;
    logic              rt_hit_s;

    // Load-use hazard: the EX load writes a nonzero register that ID reads.
    always_comb begin
        rs_hit_s = (ex_rd_r == id_rs);
        rt_hit_s = id_uses_rt & (ex_rd_r == id_rt);
        lu_s     = ex_valid_r & ex_mem_read_r & (ex_rd_r != {RA_W{1'b0}})
                 & id_valid & (rs_hit_s | rt_hit_s);
    end

    // A flush overrides a stall so that the branch target is still fetched.
    assign pc_write   = ~hold & ~(lu_s & ~flush);
    assign ifid_write = ~hold & ~(lu_s & ~flush);
    assign bubble     = ~hold & (flush | lu_s);

    // Pipeline register and counters.
    // Priority is reset, then hold, then flush bubble, then stall bubble, then normal load.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_r      <= 1'b0;
            ex_rs_r         <= {RA_W{1'b0}};
            ex_rt_r         <= {RA_W{1'b0}};
            ex_rd_r         <= {RA_W{1'b0}};
            ex_rs_data_r    <= {DATA_W{1'b0}};
            ex_rt_data_r    <= {DATA_W{1'b0}};
            ex_imm_r        <= {DATA_W{1'b0}};
            ex_reg_write_r  <= 1'b0;
            ex_mem_read_r   <= 1'b0;
            ex_mem_write_r  <= 1'b0;
            ex_mem_to_reg_r <= 1'b0;
            ex_alu_src_r    <= 1'b0;
            ex_branch_r     <= 1'b0;
            ex_alu_op_r     <= 3'b000;
            stall_cnt_r     <= {CNT_W{1'b0}};
            flush_cnt_r     <= {CNT_W{1'b0}};
        end else if (hold) begin
            ex_valid_r      <= ex_valid_r;
            ex_rs_r         <= ex_rs_r;
            ex_rt_r         <= ex_rt_r;
            ex_rd_r         <= ex_rd_r;
            ex_rs_data_r    <= ex_rs_data_r;
            ex_rt_data_r    <= ex_rt_data_r;
            ex_imm_r        <= ex_imm_r;
            ex_reg_write_r  <= ex_reg_write_r;
            ex_mem_read_r   <= ex_mem_read_r;
            ex_mem_write_r  <= ex_mem_write_r;
            ex_mem_to_reg_r <= ex_mem_to_reg_r;
            ex_alu_src_r    <= ex_alu_src_r;
            ex_branch_r     <= ex_branch_r;
            ex_alu_op_r     <= ex_alu_op_r;
            stall_cnt_r     <= stall_cnt_r;
            flush_cnt_r     <= flush_cnt_r;
        end else if (flush | lu_s) begin
            // Addresses are zeroed too, so the forwarding unit never matches on a bubble.
            ex_valid_r      <= 1'b0;
            ex_rs_r         <= {RA_W{1'b0}};
            ex_rt_r         <= {RA_W{1'b0}};
            ex_rd_r         <= {RA_W{1'b0}};
            ex_rs_data_r    <= {DATA_W{1'b0}};
            ex_rt_data_r    <= {DATA_W{1'b0}};
            ex_imm_r        <= {DATA_W{1'b0}};
            ex_reg_write_r  <= 1'b0;
            ex_mem_read_r   <= 1'b0;
            ex_mem_write_r  <= 1'b0;
            ex_mem_to_reg_r <= 1'b0;
            ex_alu_src_r    <= 1'b0;
            ex_branch_r     <= 1'b0;
            ex_alu_op_r     <= 3'b000;
            if (flush) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
                stall_cnt_r <= stall_cnt_r;
            end else begin
                flush_cnt_r <= flush_cnt_r;
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
        end else begin
            // An invalid ID slot still carries its addresses and data.
            // Its control bits are forced to zero.
            ex_valid_r      <= id_valid;
            ex_rs_r         <= id_rs;
            ex_rt_r         <= id_rt;
            ex_rd_r         <= id_rd;
            ex_rs_data_r    <= id_rs_data;
            ex_rt_data_r    <= id_rt_data;
            ex_imm_r        <= id_imm;
            ex_reg_write_r  <= id_valid & id_reg_write;
            ex_mem_read_r   <= id_valid & id_mem_read;
            ex_mem_write_r  <= id_valid & id_mem_write;
            ex_mem_to_reg_r <= id_valid & id_mem_to_reg;
            ex_alu_src_r    <= id_valid & id_alu_src;
            ex_branch_r     <= id_valid & id_branch;
            ex_alu_op_r     <= id_valid ? id_alu_op : 3'b000;
            stall_cnt_r     <= stall_cnt_r;
            flush_cnt_r     <= flush_cnt_r;
        end
    end

    assign ex_valid      = ex_valid_r;
    assign ex_rs         = ex_rs_r;
    assign ex_rt         = ex_rt_r;
    assign ex_rd         = ex_rd_r;
    assign ex_rs_data    = ex_rs_data_r;
    assign ex_rt_data    = ex_rt_data_r;
    assign ex_imm        = ex_imm_r;
    assign ex_reg_write  = ex_reg_write_r;
    assign ex_mem_read   = ex_mem_read_r;
    assign ex_mem_write  = ex_mem_write_r;
    assign ex_mem_to_reg = ex_mem_to_reg_r;
    assign ex_alu_src    = ex_alu_src_r;
    assign ex_branch     = ex_branch_r;
    assign ex_alu_op     = ex_alu_op_r;
    assign stall_cnt     = stall_cnt_r;
    assign flush_cnt     = flush_cnt_r;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the pipelined 8-bit processor, with integrated load-use hazard detection.
- Captures decoded operands, register addresses and control from ID, and presents them to the EX stage and the forwarding unit (ex_rs, ex_rt, ex_rd, ex_reg_write).
- On a load-use hazard it stalls PC and IF/ID and inserts a bubble.
- On a branch flush it squashes the ID instruction and keeps saturating counts of stalls and flushes.

Parameters:
- DATA_W, 8, datapath width.
- RA_W, 1, register address width; register 0 is hardwired zero.
- CNT_W, 8, width of the stall and flush counters.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  RA_W  source and destination addresses.
- id_uses_rt  in  1  instruction reads rt.
- id_rs_data, id_rt_data  in  DATA_W  register file read data.
- id_imm  in  DATA_W  sign-extended immediate.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch  in  1  decoded control.
- id_alu_op  in  3  ALU operation.
- flush  in  1  branch taken; squash the ID instruction.
- hold  in  1  global freeze (memory wait).
- ex_valid  out  1  EX holds a real instruction.
- ex_rs, ex_rt, ex_rd  out  RA_W  registered addresses.
- ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered operands.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch  out  1  registered control.
- ex_alu_op  out  3  registered ALU operation.
- pc_write  out  1  PC update enable (combinational).
- ifid_write  out  1  IF/ID update enable (combinational).
- bubble  out  1  a bubble is being inserted this cycle (combinational).
- stall_cnt  out  CNT_W  load-use bubbles inserted, saturating.
- flush_cnt  out  CNT_W  flushes taken, saturating.

Behaviour:
- Reset is synchronous, active-high, single clock. On reset, all ex_* registered outputs, stall_cnt and flush_cnt go to 0. Reset overrides every other input.
- Hazard detection (combinational): lu = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))).
- pc_write = ifid_write = ~hold & ~(lu & ~flush).
- bubble = ~hold & (flush | lu).
- Register update priority, per clock edge:
  1. reset: clear everything.
  2. hold: all ex_* and both counters retain their values.
  3. flush: load a bubble; flush_cnt += 1, saturating at 2^CNT_W-1.
  4. lu: load a bubble; stall_cnt += 1, saturating.
  5. otherwise: load all id_* fields; ex_valid = id_valid.
- Bubble contents: ex_valid = 0; all control outputs = 0, including ex_alu_op = 0. Address and data fields = 0, so the forwarding unit never matches on a bubble.
- If id_valid = 0 on a normal load, control outputs are forced to 0 regardless of id_* control. Address and data are still loaded.
- Latency: exactly one cycle from ID inputs to ex_* outputs.
- A load-use stall lasts exactly one cycle. The bubble clears ex_mem_read, so lu drops the next cycle and the held ID instruction then loads normally.
- A load writing rd = 0 never stalls.
- flush and lu in the same cycle: flush wins. Only flush_cnt increments; pc_write stays 1 so the branch target is fetched.
- Saturated counters hold at their maximum value; they never wrap.
- hold and flush together: nothing changes. flush is expected to persist until hold drops.
- Reset in the middle of a stall: the next cycle has ex_valid = 0 and lu = 0, and the pipeline resumes normally.

Test Plan:
- Reset: assert reset with ex_* loaded -> next cycle all ex_* = 0, counters = 0, pc_write = 1.
- Load then dependent ALU op: EX holds lw rd=1; ID holds add rs=1 -> lu = 1, pc_write = ifid_write = 0, bubble = 1. Next cycle ex_valid = 0, ex_reg_write = 0, stall_cnt = 1. The following cycle the add loads with ex_rs = 1 and pc_write = 1.
- Load to rd = 0 followed by a reader of r0 -> no stall, stall_cnt stays 0. Reader of rt with id_uses_rt = 0 and rt matching -> no stall.
- flush together with lu -> bubble loaded, flush_cnt = 1, stall_cnt = 0, pc_write = 1.
- hold = 1 for 3 cycles while ID changes each cycle -> ex_* and counters frozen, pc_write = 0. After hold drops, the current ID instruction loads.
- Force 300 load-use stalls with CNT_W = 8 -> stall_cnt reads 255 and stays at 255.
